cal_fifo_wr_skid: RTL and testbench
===================================

CAL_FIFO_WR_SKID -- requirements
Module: cal_fifo_wr_skid

Interface
REQ-001 SHALL have parameter WWIDTH, default 10: data word width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of wr_count.
REQ-003 SHALL have port pos_rclk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port aresetn_rclk  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sresetn_rclk  input  1  synchronous reset, active-low; same effect as aresetn_rclk.
REQ-006 SHALL have port s_valid  input  1  upstream word valid.
REQ-007 SHALL have port s_ready  output  1  upstream may transfer this cycle.
REQ-008 SHALL have port s_data  input  WWIDTH  upstream word.
REQ-009 SHALL have port fifo_full  input  1  FIFO write side full.
REQ-010 SHALL have port fifo_wr_en  output  1  FIFO write strobe, active-high.
REQ-011 SHALL have port fifo_din  output  WWIDTH  FIFO write data.
REQ-012 SHALL have port flush  input  1  synchronous discard of buffered words.
REQ-013 SHALL have port busy  output  1  at least one word buffered.
REQ-014 SHALL have port wr_count  output  CNT_WIDTH  words written to FIFO.

Function
REQ-015 SHALL hold up to two words: output register (drives fifo_din) and skid register.
REQ-016 SHALL implement states IDLE (0 words), HOLD1 (output reg valid), HOLD2 (both valid).
REQ-017 Transfer SHALL occur when s_valid & s_ready; write SHALL occur when fifo_wr_en.
REQ-018 fifo_wr_en SHALL equal (state != IDLE) & !fifo_full & !flush.
REQ-019 s_ready SHALL equal (state != HOLD2) & !flush; no combinational path from s_valid or fifo_full to s_ready.
REQ-020 IDLE: transfer -> HOLD1, output reg <= s_data.
REQ-021 HOLD1: transfer & write -> HOLD1, output reg <= s_data; transfer & no write -> HOLD2, skid <= s_data; write & no transfer -> IDLE; neither -> HOLD1.
REQ-022 HOLD2: write -> HOLD1, output reg <= skid; else hold; no transfer possible.
REQ-023 Word order SHALL be preserved; no word lost or duplicated.
REQ-024 Latency SHALL be 1 cycle: word transferred at edge N visible as fifo_wr_en/fifo_din in cycle N+1 if fifo_full=0.
REQ-025 Sustained throughput SHALL be 1 word/cycle while fifo_full=0.
REQ-026 fifo_full asserted: fifo_wr_en SHALL be 0; buffered words held; s_ready drops after at most one more transfer.
REQ-027 fifo_din SHALL be stable while fifo_wr_en=0 and state != IDLE.
REQ-028 flush SHALL force next state IDLE, discard both registers, suppress write and transfer that cycle.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 aresetn_rclk low or sresetn_rclk low SHALL force: state IDLE, s_ready 0 during reset, fifo_wr_en 0, fifo_din 0, busy 0, wr_count 0.
REQ-031 Reset mid-operation SHALL discard buffered words; s_ready=1 first cycle after reset release.

Configuration
REQ-032 Macro CAL_FIFO_WR_CNT_EN defined: wr_count increments by 1 on each fifo_wr_en, saturates at all-ones, cleared by reset, not by flush.
REQ-033 Macro CAL_FIFO_WR_CNT_EN undefined: wr_count tied to 0, no counter logic; port retained.

Structure
REQ-034 Package cal_fifo_pkg SHALL hold the state typedef (IDLE, HOLD1, HOLD2) and encoding constants.
REQ-035 Saturating counter SHALL be sub-module cal_fifo_sat_cnt (params CNT_WIDTH), instantiated only under CAL_FIFO_WR_CNT_EN.

Verification
REQ-036 Streaming: s_valid=1 for 8 cycles, data 0x001..0x008, fifo_full=0 -> fifo_wr_en 8 consecutive cycles, din 0x001..0x008, s_ready constant 1.
REQ-037 Backpressure: fifo_full=1 while streaming 0x010,0x011,0x012 -> 0x010,0x011 buffered, s_ready=0, 0x012 held; release -> writes 0x010,0x011,0x012 in order.
REQ-038 Flush in HOLD2 -> next cycle busy=0, no write of buffered words, next transfer 0x055 written alone.
REQ-039 Async reset mid-HOLD2 -> immediate fifo_wr_en=0, busy=0, wr_count=0; s_ready=1 cycle after release.
REQ-040 With CAL_FIFO_WR_CNT_EN, CNT_WIDTH=4: 20 writes -> wr_count=15 saturated; without macro -> wr_count=0 throughout.
REQ-041 Random s_valid/fifo_full, 10000 cycles -> scoreboard shows in-order, lossless, no write while fifo_full=1.

Source files
------------

// File: rtl/cal_fifo_pkg.sv
// Shared state type and encodings for the FIFO write-side skid buffer.
package cal_fifo_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD1 = 2'd1;
    localparam logic [1:0] ST_HOLD2 = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        HOLD1 = ST_HOLD1,
        HOLD2 = ST_HOLD2
    } state_t;

endpackage

// File: rtl/cal_fifo_sat_cnt.sv
// Saturating up-counter for words written to the FIFO; sticks at all-ones.
module cal_fifo_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 pos_rclk,
    input  logic                 aresetn_rclk,
    input  logic                 sresetn_rclk,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            count <= '0;
        end else if (!sresetn_rclk) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/cal_fifo_wr_skid.sv
// Two-entry skid buffer in front of a FIFO write port, with flush and write counter.
// Define CAL_FIFO_WR_CNT_EN to build the saturating wr_count; otherwise wr_count is 0.
module cal_fifo_wr_skid
    import cal_fifo_pkg::*;
#(
    parameter int WWIDTH    = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 pos_rclk,
    input  logic                 aresetn_rclk,
    input  logic                 sresetn_rclk,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WWIDTH-1:0]    s_data,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [WWIDTH-1:0]    fifo_din,
    input  logic                 flush,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] wr_count
);

    state_t            state;
    logic [WWIDTH-1:0] out_q;
    logic [WWIDTH-1:0] skid_q;
    logic              transfer;

    // s_ready depends only on state, flush and the resets, never on s_valid or fifo_full.
    assign s_ready    = aresetn_rclk & sresetn_rclk & (state != HOLD2) & ~flush;
    assign fifo_wr_en = sresetn_rclk & (state != IDLE) & ~fifo_full & ~flush;
    assign busy       = sresetn_rclk & (state != IDLE);
    assign fifo_din   = sresetn_rclk ? out_q : '0;
    assign transfer   = s_valid & s_ready;

    // NOTE: state and data registers use non-blocking assignments so every branch
    // sees the pre-edge values; the skid word is cleared too so a flushed word never
    // reappears on fifo_din.
    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            state  <= IDLE;
            out_q  <= '0;
            skid_q <= '0;
        end else if (!sresetn_rclk || flush) begin
            state  <= IDLE;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state <= HOLD1;
                        out_q <= s_data;
                    end
                end
                HOLD1: begin
                    case ({transfer, fifo_wr_en})
                        2'b11:   out_q <= s_data;
                        2'b10: begin
                            state  <= HOLD2;
                            skid_q <= s_data;
                        end
                        2'b01:   state <= IDLE;
                        default: ;
                    endcase
                end
                HOLD2: begin
                    // The skid word moves forward as the output word drains.
                    if (fifo_wr_en) begin
                        state <= HOLD1;
                        out_q <= skid_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAL_FIFO_WR_CNT_EN
    logic [CNT_WIDTH-1:0] cnt;

    cal_fifo_sat_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_sat_cnt (
        .pos_rclk    (pos_rclk),
        .aresetn_rclk(aresetn_rclk),
        .sresetn_rclk(sresetn_rclk),
        .inc         (fifo_wr_en),
        .count       (cnt)
    );

    assign wr_count = sresetn_rclk ? cnt : '0;
`else
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_cal_fifo_wr_skid.sv
// Scoreboard bench for cal_fifo_wr_skid: directed scenarios followed by random traffic.
module tb_cal_fifo_wr_skid;

    localparam int WW = 10;
    localparam int CW = 4;

    logic          pos_rclk = 1'b0;
    logic          aresetn_rclk;
    logic          sresetn_rclk;
    logic          s_valid;
    logic          s_ready;
    logic [WW-1:0] s_data;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [WW-1:0] fifo_din;
    logic          flush;
    logic          busy;
    logic [CW-1:0] wr_count;

    cal_fifo_wr_skid #(
        .WWIDTH   (WW),
        .CNT_WIDTH(CW)
    ) dut (
        .pos_rclk    (pos_rclk),
        .aresetn_rclk(aresetn_rclk),
        .sresetn_rclk(sresetn_rclk),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .flush       (flush),
        .busy        (busy),
        .wr_count    (wr_count)
    );

    always #5 pos_rclk = ~pos_rclk;

    int tests = 0;
    int fails = 0;

    // Reference model: the words accepted but not yet written, oldest first (at most two).
    logic [WW-1:0] sb[$];
    int            n_writes = 0;
    logic          ready_q  = 1'b0;

    logic    m_rst, exp_ready, exp_wr, exp_busy;
    int      exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs mid-cycle, then retires the words the coming edge writes.
    always @(negedge pos_rclk) begin
        m_rst     = !aresetn_rclk || !sresetn_rclk;
        exp_ready = !m_rst && (sb.size() < 2) && !flush;
        exp_wr    = !m_rst && (sb.size() > 0) && !fifo_full && !flush;
        exp_busy  = !m_rst && (sb.size() > 0);
`ifdef CAL_FIFO_WR_CNT_EN
        exp_cnt   = m_rst ? 0 : ((n_writes > 15) ? 15 : n_writes);
`else
        exp_cnt   = 0;
`endif
        check("s_ready", 32'(s_ready), 32'(exp_ready));
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        check("busy", 32'(busy), 32'(exp_busy));
        check("wr_count", 32'(wr_count), 32'(exp_cnt));
        if (exp_busy)
            check("fifo_din", 32'(fifo_din), 32'(sb[0]));
        else if (m_rst)
            check("fifo_din_rst", 32'(fifo_din), 32'd0);

        if (m_rst) begin
            sb.delete();
            n_writes = 0;
        end else if (flush) begin
            sb.delete();
        end else if (exp_wr) begin
            void'(sb.pop_front());
            n_writes++;
        end
        ready_q = exp_ready;
    end

    // Apply inputs for one cycle; a transfer the model accepts is pushed at the edge.
    task automatic drive(input logic v, input logic [WW-1:0] d, input logic f, input logic fl);
        s_valid   = v;
        s_data    = d;
        fifo_full = f;
        flush     = fl;
        @(posedge pos_rclk);
        if (v && ready_q) sb.push_back(d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        aresetn_rclk = 1'b0;
        sresetn_rclk = 1'b1;
        s_valid      = 1'b0;
        s_data       = '0;
        fifo_full    = 1'b0;
        flush        = 1'b0;
        idle(2);
        aresetn_rclk = 1'b1;
        idle(1);

        // Streaming 0x001..0x008 at full rate.
        for (int i = 1; i <= 8; i++) drive(1'b1, WW'(i), 1'b0, 1'b0);
        idle(3);

        // Backpressure: two words buffered, third held upstream until release.
        drive(1'b1, 10'h010, 1'b1, 1'b0);
        drive(1'b1, 10'h011, 1'b1, 1'b0);
        drive(1'b1, 10'h012, 1'b1, 1'b0);
        drive(1'b1, 10'h012, 1'b1, 1'b0);
        drive(1'b1, 10'h012, 1'b0, 1'b0);
        drive(1'b0, 10'h000, 1'b0, 1'b0);
        idle(3);

        // Flush while holding two words, then a lone word.
        drive(1'b1, 10'h020, 1'b1, 1'b0);
        drive(1'b1, 10'h021, 1'b1, 1'b0);
        drive(1'b1, 10'h099, 1'b0, 1'b1);
        drive(1'b1, 10'h055, 1'b0, 1'b0);
        idle(3);

        // Asynchronous reset mid-HOLD2.
        drive(1'b1, 10'h030, 1'b1, 1'b0);
        drive(1'b1, 10'h031, 1'b1, 1'b0);
        #2;
        aresetn_rclk = 1'b0;
        #1;
        check("arst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_count", 32'(wr_count), 32'd0);
        check("arst_ready", 32'(s_ready), 32'd0);
        drive(1'b1, 10'h032, 1'b0, 1'b0);
        drive(1'b1, 10'h033, 1'b0, 1'b0);
        aresetn_rclk = 1'b1;
        drive(1'b1, 10'h034, 1'b0, 1'b0);
        idle(3);

        // Enough writes to saturate a 4-bit counter.
        for (int i = 0; i < 20; i++) drive(1'b1, WW'(10'h100 + i), 1'b0, 1'b0);
        idle(3);

        // Random traffic including occasional flush and synchronous reset.
        for (int i = 0; i < 10000; i++) begin
            sresetn_rclk = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 3) != 0), WW'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
        end
        sresetn_rclk = 1'b1;
        idle(4);
        check("drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
